// File: rtl/uart_pkg.sv
// Shared state encoding, oversampling constants and baud divisor helper for uart_param_core.
package uart_pkg;

  typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} uart_state_e;

  localparam int unsigned OVS = 16;
  localparam int unsigned MID = 8;

  // Divisor from clk to the 16x oversample strobe, rounded to nearest.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + (OVS * baud) / 2) / (OVS * baud);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; head shows the oldest entry while not empty.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [2**AW];

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    head  = mem_q[rd_ptr_q[AW-1:0]];
  end

endmodule

// File: rtl/uart_param_core.sv
// Single-clock UART: baud strobe, 16x-oversampled RX into a FIFO, TX, and RX->TX echo path.
// Define UART_PARITY_EN to add an even parity bit after the data bits in both directions.
module uart_param_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 20000000,
  parameter int unsigned BAUD      = 1200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned FIFO_AW   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ser_in,
  output logic                 ser_out,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  input  logic                 echo_en,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 baud_tick
);

  localparam int unsigned   DIV       = calc_div(CLK_HZ, BAUD);
  localparam int unsigned   CW        = $clog2(DIV);
  localparam logic [CW-1:0] TICK_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] TICK_ONE  = CW'(1);
  localparam logic [3:0]    CNT_LAST  = 4'(OVS - 1);
  localparam logic [3:0]    CNT_MID   = 4'(MID - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

  logic [CW-1:0]        tick_cnt_q, tick_cnt_d;
  logic                 sync1_q, sync2_q, rx_line_q, rx_line_d;
  uart_state_e          rx_state_q, rx_state_d, tx_state_q, tx_state_d;
  logic [3:0]           rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic [2:0]           rx_bit_q, rx_bit_d, tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
  logic                 rx_perr_q, rx_perr_d, tx_par_q, tx_par_d, ser_out_q, ser_out_d;

  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_head, tx_load_data;
  logic                 rx_stop_mid, rx_good, tx_idle, echo_pop, tx_load;

  uart_sync_fifo #(
    .WIDTH(DATA_BITS),
    .AW   (FIFO_AW)
  ) u_rx_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .pop  (fifo_pop),
    .wdata(rx_shift_q),
    .full (fifo_full),
    .empty(fifo_empty),
    .head (fifo_head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rx_line_q  <= 1'b1;
      rx_state_q <= StIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_perr_q  <= 1'b0;
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      ser_out_q  <= 1'b1;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      sync1_q    <= ser_in;
      sync2_q    <= sync1_q;
      rx_line_q  <= rx_line_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_perr_q  <= rx_perr_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      ser_out_q  <= ser_out_d;
    end
  end

  always_comb begin
    tick_cnt_d = baud_tick ? '0 : tick_cnt_q + TICK_ONE;
  end

  // RX next state; rx_line_q holds the previous tick sample so a start needs a 1->0 edge.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_perr_d  = rx_perr_q;
    rx_line_d  = rx_line_q;
    if (baud_tick) begin
      rx_line_d = sync2_q;
      rx_cnt_d  = rx_cnt_q + 4'd1;
      unique case (rx_state_q)
        StIdle: begin
          if (!sync2_q && rx_line_q) begin
            rx_state_d = StStart;
            rx_cnt_d   = '0;
            rx_perr_d  = 1'b0;
          end
        end
        StStart: begin
          if (rx_cnt_q == CNT_MID) begin
            rx_state_d = sync2_q ? StIdle : StData;
            rx_cnt_d   = '0;
            rx_bit_d   = '0;
          end
        end
        StData: begin
          if (rx_cnt_q == CNT_LAST) begin
            rx_cnt_d   = '0;
            rx_bit_d   = rx_bit_q + 3'd1;
            rx_shift_d = {sync2_q, rx_shift_q[DATA_BITS-1:1]};
            if (rx_bit_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
              rx_state_d = StPar;
`else
              rx_state_d = StStop;
`endif
            end
          end
        end
        StPar: begin
          if (rx_cnt_q == CNT_LAST) begin
            rx_state_d = StStop;
            rx_cnt_d   = '0;
            rx_perr_d  = sync2_q ^ (^rx_shift_q);
          end
        end
        StStop: begin
          if (rx_cnt_q == CNT_LAST) rx_state_d = StIdle;
        end
        default: rx_state_d = StIdle;
      endcase
    end
  end

  // TX next state; a load always wins because it only happens in idle.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    ser_out_d  = ser_out_q;
    if (tx_load) begin
      tx_state_d = StStart;
      tx_cnt_d   = '0;
      tx_shift_d = tx_load_data;
      tx_par_d   = ^tx_load_data;
      ser_out_d  = 1'b0;
    end else if (baud_tick && !tx_idle) begin
      tx_cnt_d = tx_cnt_q + 4'd1;
      if (tx_cnt_q == CNT_LAST) begin
        tx_cnt_d = '0;
        unique case (tx_state_q)
          StStart: begin
            tx_state_d = StData;
            tx_bit_d   = '0;
            ser_out_d  = tx_shift_q[0];
          end
          StData: begin
            if (tx_bit_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
              tx_state_d = StPar;
              ser_out_d  = tx_par_q;
`else
              tx_state_d = StStop;
              ser_out_d  = 1'b1;
`endif
            end else begin
              tx_bit_d   = tx_bit_q + 3'd1;
              tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
              ser_out_d  = tx_shift_q[1];
            end
          end
          StPar: begin
            tx_state_d = StStop;
            ser_out_d  = 1'b1;
          end
          default: begin
            tx_state_d = StIdle;
            ser_out_d  = 1'b1;
          end
        endcase
      end
    end
  end

  always_comb begin
    baud_tick    = (tick_cnt_q == TICK_LAST);
    rx_stop_mid  = baud_tick && (rx_state_q == StStop) && (rx_cnt_q == CNT_LAST);
    rx_good      = rx_stop_mid && sync2_q && !rx_perr_q;
    frame_err    = rx_stop_mid && (!sync2_q || rx_perr_q);
    tx_idle      = (tx_state_q == StIdle);
    tx_ready     = tx_idle && !echo_en;
    echo_pop     = tx_idle && echo_en && !fifo_empty;
    tx_load      = (tx_valid && tx_ready) || echo_pop;
    tx_load_data = echo_pop ? fifo_head : tx_data;
    rx_valid     = !fifo_empty && !echo_en;
    rx_data      = fifo_empty ? '0 : fifo_head;
    fifo_pop     = echo_pop || (rx_valid && rx_ready);
    // A pop in the same cycle frees the slot, so a full FIFO still takes the byte.
    overrun      = rx_good && fifo_full && !fifo_pop;
    fifo_push    = rx_good && !overrun;
    ser_out      = ser_out_q;
  end

endmodule

// File: tb/tb_uart_param_core.sv
// Directed bench for uart_param_core at DIV=10 with a two-entry RX FIFO and byte scoreboards.
module tb_uart_param_core;

`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int BT = 160;

  logic       clk, rst, ser_in, ser_out, tx_valid, tx_ready, rx_valid, rx_ready;
  logic       echo_en, frame_err, overrun, baud_tick;
  logic [7:0] tx_data, rx_data;

  int         n_assert = 0;
  int         n_fail = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         echo_viol = 0;
  logic       echo_watch = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic       s_bits [0:NB*BT];
  logic       r_bits [0:NB*BT];
  logic       exp_bits [NB];

  uart_param_core #(
    .CLK_HZ   (1600000),
    .BAUD     (10000),
    .DATA_BITS(8),
    .FIFO_AW  (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ser_in   (ser_in),
    .ser_out  (ser_out),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .echo_en  (echo_en),
    .frame_err(frame_err),
    .overrun  (overrun),
    .baud_tick(baud_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overrun) ov_cnt <= ov_cnt + 1;
    if (echo_watch && (tx_ready || rx_valid)) echo_viol <= echo_viol + 1;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    ser_in = b;
    wait_clks(BT);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_PARITY_EN
    drive_bit(^d);
`endif
    drive_bit(stop_bit);
    ser_in = 1'b1;
  endtask

`ifdef UART_PARITY_EN
  task automatic send_bad_par(input logic [7:0] d);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(~(^d));
    drive_bit(1'b1);
  endtask
`endif

  task automatic pop_check(input string tag);
    logic [7:0] exp;
    exp = rx_q.pop_front();
    check({tag, " rx_valid"}, rx_valid, 1);
    check({tag, " rx_data"}, rx_data, exp);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  // Finds a TX frame on ser_out, samples mid-bit and compares with the TX scoreboard.
  task automatic tx_capture(input string tag);
    logic [7:0] got, exp;
    int t;
    t = 0;
    got = '0;
    while (ser_out !== 1'b0 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check({tag, " start found"}, (t < 4000), 1);
    wait_clks(BT / 2);
    check({tag, " start bit"}, ser_out, 0);
    for (int i = 0; i < 8; i++) begin
      wait_clks(BT);
      got[i] = ser_out;
    end
`ifdef UART_PARITY_EN
    wait_clks(BT);
    check({tag, " parity bit"}, ser_out, ^got);
`endif
    wait_clks(BT);
    check({tag, " stop bit"}, ser_out, 1);
    exp = tx_q.pop_front();
    check({tag, " data"}, got, exp);
  endtask

  initial begin
    int t, m, fe0, ov0, ev0;
    logic [7:0] d;

    rst = 1'b1;
    ser_in = 1'b1;
    tx_valid = 1'b0;
    tx_data = '0;
    rx_ready = 1'b0;
    echo_en = 1'b0;
    wait_clks(3);
    check("rst ser_out", ser_out, 1);
    check("rst tx_ready", tx_ready, 1);
    check("rst rx_valid", rx_valid, 0);
    check("rst rx_data", rx_data, 0);
    check("rst frame_err", frame_err, 0);
    check("rst overrun", overrun, 0);
    check("rst baud_tick", baud_tick, 0);
    rst = 1'b0;
    wait_clks(2);

    // TX 0xA5 accepted on a tick edge so the start bit is exactly 16 ticks long.
    d = 8'hA5;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[i + 1] = d[i];
`ifdef UART_PARITY_EN
    exp_bits[9] = ^d;
`endif
    exp_bits[NB - 1] = 1'b1;
    t = 0;
    while (baud_tick !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("tick align", (t < 20), 1);
    tx_data = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int i = 0; i <= NB * BT; i++) begin
      s_bits[i] = ser_out;
      r_bits[i] = tx_ready;
      @(negedge clk);
    end
    for (int k = 0; k < NB; k++) begin
      m = 0;
      for (int j = 0; j < BT; j++) if (s_bits[BT * k + j] === exp_bits[k]) m++;
      check($sformatf("tx bit %0d", k), m, BT);
    end
    m = 0;
    for (int i = 0; i < NB * BT; i++) if (r_bits[i] === 1'b0) m++;
    check("tx_ready low cycles", m, NB * BT);
    check("tx_ready after frame", r_bits[NB * BT], 1);
    check("ser_out idle after frame", s_bits[NB * BT], 1);

    // Clean RX frame.
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    rx_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    wait_clks(2);
    pop_check("rx 3c");
    check("rx 3c empty after pop", rx_valid, 0);
    check("rx 3c frame_err", fe_cnt, fe0);
    check("rx 3c overrun", ov_cnt, ov0);

    // Bad stop bit.
    send_frame(8'h5A, 1'b0);
    wait_clks(20);
    check("stop0 frame_err pulses", fe_cnt, fe0 + 1);
    check("stop0 rx_valid", rx_valid, 0);

    // Short low glitch must not start a frame; a following frame must still be received.
    fe0 = fe_cnt;
    ser_in = 1'b0;
    wait_clks(40);
    ser_in = 1'b1;
    wait_clks(200);
    check("glitch rx_valid", rx_valid, 0);
    check("glitch frame_err", fe_cnt, fe0);
    rx_q.push_back(8'h96);
    send_frame(8'h96, 1'b1);
    wait_clks(2);
    pop_check("rx after glitch");

    // Two-entry FIFO overflows on the third byte.
    ov0 = ov_cnt;
    fe0 = fe_cnt;
    rx_q.push_back(8'h11);
    rx_q.push_back(8'h22);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    wait_clks(2);
    check("overrun pulses", ov_cnt, ov0 + 1);
    check("overrun frame_err", fe_cnt, fe0);
    pop_check("fifo pop 1");
    pop_check("fifo pop 2");
    check("fifo drained", rx_valid, 0);

    // Echo path.
    echo_en = 1'b1;
    wait_clks(2);
    ev0 = echo_viol;
    echo_watch = 1'b1;
    tx_q.push_back(8'h55);
    fork
      send_frame(8'h55, 1'b1);
      tx_capture("echo");
    join
    wait_clks(100);
    echo_watch = 1'b0;
    check("echo host ports blocked", echo_viol, ev0);
    echo_en = 1'b0;
    wait_clks(2);
    check("echo fifo consumed", rx_valid, 0);

    // Reset in the middle of a TX frame with a byte waiting in the FIFO.
    send_frame(8'h77, 1'b1);
    wait_clks(2);
    check("pre-reset rx_valid", rx_valid, 1);
    tx_data = 8'h0F;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_clks(500);
    rst = 1'b1;
    @(negedge clk);
    check("midrst ser_out", ser_out, 1);
    check("midrst tx_ready", tx_ready, 1);
    check("midrst rx_valid", rx_valid, 0);
    check("midrst rx_data", rx_data, 0);
    rst = 1'b0;
    wait_clks(2);
    tx_q.push_back(8'hC3);
    tx_data = 8'hC3;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_capture("tx after reset");
    wait_clks(200);

`ifdef UART_PARITY_EN
    fe0 = fe_cnt;
    send_bad_par(8'h81);
    wait_clks(20);
    check("parity frame_err", fe_cnt, fe0 + 1);
    check("parity rx_valid", rx_valid, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_param_core.md
Name: uart_param_core

Overview:
Parametrised successor to the fixed 1200-baud echo UART. A single-clock UART with a clock-enable baud generator (no derived clocks), 16x-oversampled receiver, transmitter, RX FIFO, and a runtime-selectable echo path (RX FIFO -> TX). Sits between the board serial pins and the host logic; DATA_BITS, baud rate and FIFO depth are configurable.

Parameters:
- CLK_HZ, 20000000, system clock frequency in Hz.
- BAUD, 1200, serial bit rate. DIV = round(CLK_HZ/(16*BAUD)), must be >= 2.
- DATA_BITS, 8, payload bits per frame, legal range 5..8.
- FIFO_AW, 3, RX FIFO address width; depth = 2**FIFO_AW.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ser_in  in  1  asynchronous serial input, idle high.
- ser_out  out  1  serial output, idle high.
- tx_data  in  DATA_BITS  byte to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  transmitter accepts a byte this cycle.
- rx_data  out  DATA_BITS  head of the RX FIFO.
- rx_valid  out  1  RX FIFO not empty, and echo disabled.
- rx_ready  in  1  consumer pops the RX FIFO.
- echo_en  in  1  1 = received bytes are retransmitted and the host ports are blocked.
- frame_err  out  1  one-cycle pulse: bad stop bit or parity error.
- overrun  out  1  one-cycle pulse: byte dropped because the FIFO was full.
- baud_tick  out  1  16x oversample strobe, for monitoring.

Behaviour:
- Reset: ser_out=1, tx_ready=1, rx_valid=0, rx_data=0, frame_err=0, overrun=0, baud_tick=0. The FIFO, both FSMs and the tick counter are cleared. A reset mid-frame forces ser_out=1 on the next cycle.
- Tick generator: counter runs 0..DIV-1. baud_tick is high for one clk when counter==DIV-1, then the counter wraps to 0.
- ser_in passes through a 2-flop synchroniser (reset value 1). All RX decisions use the synchronised value.
- RX FSM, states IDLE, START, DATA, PAR, STOP. Transitions occur only on baud_tick.
  - IDLE -> START when sampled 0.
  - START: after 8 ticks, resample. If 1, treat as a glitch and return to IDLE. If 0, go to DATA.
  - DATA: sample every 16 ticks, LSB first, DATA_BITS samples, then go to PAR (if parity is compiled in) or STOP.
  - STOP: sample after 16 ticks.
    - If 1 and the FIFO is not full: push the byte.
    - If 1 and the FIFO is full: drop the byte and pulse overrun.
    - If 0: drop the byte and pulse frame_err.
  - Return to IDLE in the same cycle. No wait for line high; the next start is detected only after a 1 is sampled.
- FIFO: synchronous, first-word fall-through; rx_data = head.
  - Pop when rx_valid & rx_ready.
  - A simultaneous push and pop on a full FIFO is a legal push (no overrun).
- TX FSM, states IDLE, START, DATA, PAR, STOP. tx_ready = (state==IDLE) & ~echo_en.
  - Accept on tx_valid & tx_ready.
  - Each bit lasts 16 baud_ticks, counted from the first tick after acceptance. ser_out drives 0 from the cycle after acceptance.
  - Frame = 1 start bit, DATA_BITS data bits LSB first, [parity], 1 stop bit.
  - tx_ready returns high the cycle after the last stop tick. Back-to-back frames have no idle gap.
- Echo: when echo_en=1 and TX is IDLE with the FIFO non-empty, TX pops the FIFO head. rx_valid is forced 0.
  - echo_en is sampled only in TX IDLE; a frame in flight always completes.
- tx_data is ignored while tx_valid=0. Widths above DATA_BITS do not exist.

Optional Feature:
- UART_PARITY_EN
  - Defined: even parity bit after the data bits on TX. RX checks the parity bit; on mismatch it pulses frame_err and drops the byte (the stop bit is still sampled).
  - Undefined: 8N1-style framing, no PAR state, frame length 2+DATA_BITS bits.

Decomposition:
- Package uart_pkg:
  - RX/TX state enum.
  - OVS=16 and MID=8 constants.
  - Function computing DIV from CLK_HZ/BAUD with rounding.
- Sub-module uart_sync_fifo (params WIDTH, AW; push/pop/full/empty/head). The tick generator and both FSMs stay in the top.

Test Plan:
- CLK_HZ=1600000, BAUD=10000 (DIV=10): send tx_data=0xA5 -> ser_out goes 0 for 160 clks, then 1,0,1,0,0,1,0,1 (160 clks each), then 1. tx_ready is low for 1600 clks.
- Drive a 0x3C frame on ser_in -> rx_valid rises within 4 clks of the stop-bit mid-sample with rx_data=0x3C. frame_err and overrun stay 0.
- Frame with stop bit 0 -> one frame_err pulse, rx_valid stays 0. A 4-tick low glitch on ser_in -> no activity, RX back in IDLE.
- FIFO_AW=1, rx_ready=0, send 0x11, 0x22, 0x33 -> overrun pulses on the third byte. Pops return 0x11 then 0x22.
- echo_en=1, send 0x55 on ser_in -> an identical frame appears on ser_out after RX completes. tx_ready=0 and rx_valid=0 throughout.
- Assert rst mid-TX frame -> ser_out=1 on the next cycle, tx_ready=1, FIFO empty. With UART_PARITY_EN, inject a bad parity bit -> frame_err pulse, byte dropped.
